// File: rtl/pcie_lane_striper.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pcie_lane_striper                                               |
// | Purpose  : Gathers a serial byte stream round-robin into LANES lane slots  |
// |            and launches lane-aligned frames. Partial frames are padded.     |
// |            Optional per-lane parity is enabled by STRIPER_PARITY_EN.        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module pcie_lane_striper #(
  parameter int         LANES       = 4,
  parameter logic [7:0] PAD_SYMBOL  = 8'hF7,
  parameter logic [7:0] IDLE_SYMBOL = 8'h00,
  parameter int         CNT_W       = 16
) (
  input  logic                 CLK,
  input  logic                 reset,
  input  logic [7:0]           data_in,
  input  logic                 valid_in,
  input  logic                 eop_in,
  output logic [8*LANES-1:0]   lane_data,
  output logic                 lane_valid,
  output logic [LANES-1:0]     lane_pad_mask,
  output logic [CNT_W-1:0]     frame_count,
  output logic [LANES-1:0]     lane_parity
);

  localparam int                  c_PTR_W     = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [c_PTR_W-1:0]  c_PTR_LAST  = c_PTR_W'(LANES - 1);
  localparam logic [8*LANES-1:0]  c_IDLE_WORD = {LANES{IDLE_SYMBOL}};

  logic [c_PTR_W-1:0]  r_ptr;
  logic [7:0]          r_stage [LANES];
  logic [8*LANES-1:0]  r_lane_data;
  logic                r_lane_valid;
  logic [LANES-1:0]    r_pad_mask;
  logic [CNT_W-1:0]    r_count;

  logic                w_launch;
  logic [8*LANES-1:0]  w_frame;
  logic [LANES-1:0]    w_pad;

  // Lanes below ptr come from staging, lane ptr from the live byte if valid,
  // and everything above is padding; only meaningful when w_launch is set.
  always_comb begin
    w_launch = 1'b0;
    if (valid_in) begin
      w_launch = eop_in || (r_ptr == c_PTR_LAST);
    end else if (eop_in) begin
      w_launch = (r_ptr != '0);
    end

    w_frame = c_IDLE_WORD;
    w_pad   = '0;
    for (int k = 0; k < LANES; k++) begin
      if (k < int'(r_ptr)) begin
        w_frame[8*k +: 8] = r_stage[k];
      end else if (valid_in && (k == int'(r_ptr))) begin
        w_frame[8*k +: 8] = data_in;
      end else begin
        w_frame[8*k +: 8] = PAD_SYMBOL;
        w_pad[k]          = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_ptr <= '0;
      for (int k = 0; k < LANES; k++) begin
        r_stage[k] <= '0;
      end
    end else begin
      if (valid_in) begin
        r_stage[r_ptr] <= data_in;
      end
      if (w_launch) begin
        r_ptr <= '0;
      end else if (valid_in) begin
        r_ptr <= r_ptr + c_PTR_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_lane_data  <= c_IDLE_WORD;
      r_lane_valid <= 1'b0;
      r_pad_mask   <= '0;
      r_count      <= '0;
    end else begin
      r_lane_valid <= w_launch;
      r_lane_data  <= w_launch ? w_frame : c_IDLE_WORD;
      r_pad_mask   <= w_launch ? w_pad : '0;
      if (w_launch) begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  assign lane_data     = r_lane_data;
  assign lane_valid    = r_lane_valid;
  assign lane_pad_mask = r_pad_mask;
  assign frame_count   = r_count;

`ifdef STRIPER_PARITY_EN
  localparam logic [LANES-1:0] c_IDLE_PAR = {LANES{^IDLE_SYMBOL}};

  logic [LANES-1:0] w_par;
  logic [LANES-1:0] r_parity;

  always_comb begin
    w_par = '0;
    for (int k = 0; k < LANES; k++) begin
      w_par[k] = ^w_frame[8*k +: 8];
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_parity <= c_IDLE_PAR;
    end else begin
      r_parity <= w_launch ? w_par : c_IDLE_PAR;
    end
  end

  assign lane_parity = r_parity;
`else
  assign lane_parity = '0;
`endif

endmodule
`default_nettype wire
